// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue stage.
//   OP_*          : ALU opcode encodings
//   cmd_t         : packed queued command {op, c, a, b}, 12 bits
//   issue_state_t : issue FSM state
package alu_pkg;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] c;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_queue_fifo.sv
// alu_cmd_fifo: synchronous FIFO of cmd_t.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write pushData at the tail (caller guarantees not full)
//   pop        : advance the head (caller guarantees not empty)
//   headData   : current head entry, valid whenever count != 0
//   count      : occupancy 0..DEPTH
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  cmd_t                         pushData,
    input  logic                         pop,
    output cmd_t                         headData,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); full/empty come from count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command issue stage in front of a 4-bit combinational ALU.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : upstream command handshake
//   in_a, in_b, in_c, in_op : command fields
//   alu_a/b/c/op          : registered ALU input drive
//   alu_ans               : ALU combinational result
//   res_valid/res_ready   : downstream result handshake
//   res_data              : registered ALU result
//   count                 : queued command count 0..DEPTH
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_a,
    input  logic [DATA_W-1:0]           in_b,
    input  logic [1:0]                  in_c,
    input  logic [1:0]                  in_op,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [1:0]                  alu_c,
    output logic [1:0]                  alu_op,
    input  logic [DATA_W-1:0]           alu_ans,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DATA_W-1:0]           res_data,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    issue_state_t state;
    cmd_t         pushCmd;
    cmd_t         headCmd;
    logic         pushEn;
    logic         popEn;

    assign in_ready = (count != CNT_W'(DEPTH));
    assign pushEn   = in_valid && in_ready;
    assign pushCmd  = '{op: in_op, c: in_c, a: in_a, b: in_b};

    // Pop decision uses registered count only, so a command pushed this
    // cycle can never be issued in the same cycle.
    always_comb begin
        popEn = 1'b0;
        if (count != '0) begin
            popEn = (state == IDLE) || ((state == HOLD) && res_ready);
        end
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) cmdFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pushEn),
        .pushData (pushCmd),
        .pop      (popEn),
        .headData (headCmd),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (popEn) begin
                        alu_a  <= headCmd.a;
                        alu_b  <= headCmd.b;
                        alu_c  <= headCmd.c;
                        alu_op <= headCmd.op;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_ans;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (popEn) begin
                            alu_a  <= headCmd.a;
                            alu_b  <= headCmd.b;
                            alu_c  <= headCmd.c;
                            alu_op <= headCmd.op;
                            state  <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
